// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: ROM sequence-check game (control unit + datapath); optional timeout via TIMEOUT_EN
module circuito_jogo_param #(
  parameter int DATA_W = 4,
  parameter int DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              db_igual,
  output logic              db_jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_chaves,
  output logic [3:0]        db_estado,
  output logic              db_timeout
);
  typedef enum logic [3:0] {
    INICIAL = 4'h0, PREPARA = 4'h1, ESPERA = 4'h2, REGISTRA = 4'h4, COMPARA = 4'h5,
    PROXIMO = 4'h6, FIM_ACERTO = 4'hA, FIM_TIMEOUT = 4'hD, FIM_ERRO = 4'hE
  } estado_t;
  estado_t estado, proximo;
  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] jogada_reg;
  logic prev, expirou, ultima;
`ifdef TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [T_W-1:0] tempo;
  assign expirou = tempo == T_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock)
    if (reset || estado == PREPARA || estado == PROXIMO) tempo <= '0;
    else if (estado == ESPERA) tempo <= tempo + 1'b1;
  assign db_timeout = estado == FIM_TIMEOUT;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expirou = 1'b0;
  assign db_timeout = 1'b0;
`endif
  // one-hot walking ROM pattern
  assign db_memoria = DATA_W'(1) << (32'(contagem) % DATA_W);
  assign db_igual = jogada_reg == db_memoria;
  assign db_jogada = (|chaves) & ~prev;
  assign ultima = contagem == ADDR_W'(DEPTH - 1);
  always_ff @(posedge clock)
    if (reset) begin
      estado <= INICIAL;
      contagem <= '0;
      jogada_reg <= '0;
      prev <= 1'b0;
    end else begin
      estado <= proximo;
      prev <= |chaves;
      if (estado == PREPARA) begin
        contagem <= '0;
        jogada_reg <= '0;
      end else if (estado == REGISTRA) jogada_reg <= chaves;
      else if (estado == PROXIMO) contagem <= contagem + 1'b1;
    end
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:     proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:     proximo = ESPERA;
      ESPERA:      proximo = db_jogada ? REGISTRA : expirou ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    proximo = COMPARA;
      COMPARA:     proximo = !db_igual ? FIM_ERRO : ultima ? FIM_ACERTO : PROXIMO;
      PROXIMO:     proximo = ESPERA;
      FIM_ACERTO:  proximo = iniciar ? PREPARA : FIM_ACERTO;
      FIM_ERRO:    proximo = iniciar ? PREPARA : FIM_ERRO;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: proximo = iniciar ? PREPARA : FIM_TIMEOUT;
`endif
      default:     proximo = INICIAL;
    endcase
  end
  assign acertou = estado == FIM_ACERTO;
  assign errou = estado == FIM_ERRO || estado == FIM_TIMEOUT;
  assign pronto = acertou | errou;
  assign db_contagem = contagem;
  assign db_chaves = jogada_reg;
  assign db_estado = estado;
endmodule

// File: doc/circuito_jogo_param.md
# circuito_jogo_param

Parametrised sequence-check circuit: a control unit plus datapath that walks a DEPTH-entry built-in ROM and checks each user play against the current entry. A play is one press of the switches, detected on the rising edge of "any switch on". The game ends in a success or error state and can be restarted. It is the generalised successor of the fixed 4-bit, 16-position memory walker, and drives the same debug displays through external hexa7seg instances.

## Interface
- DATA_W, 4, switch/ROM word width (1..8)
- DEPTH, 16, number of ROM positions / plays per round (2..16); ADDR_W = clog2(DEPTH) localparam
- TIMEOUT_CYCLES, 5000, cycles allowed in wait state before timeout (used only with macro)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- iniciar  in  1  start/restart request (level, sampled each cycle)
- chaves  in  DATA_W  user switches
- pronto  out  1  round finished (success, error or timeout)
- acertou  out  1  round finished with all plays correct
- errou  out  1  round finished on a wrong play or timeout
- db_igual  out  1  registered play == ROM[contagem] (combinational compare)
- db_jogada  out  1  one-cycle play-edge pulse
- db_contagem  out  ADDR_W  current ROM address
- db_memoria  out  DATA_W  ROM[contagem]
- db_chaves  out  DATA_W  play register contents
- db_estado  out  4  state code
- db_timeout  out  1  timeout end state; constant 0 without macro

## Operation
- ROM content fixed: ROM[i] = 1 << (i mod DATA_W), i.e. one-hot walking pattern.
- Edge detector: prev <= |chaves every cycle; db_jogada = (|chaves) & ~prev. Active in every state; only consumed in ESPERA.
- States (db_estado code):
  - INICIAL (0): idle; iniciar=1 -> PREPARA.
  - PREPARA (1): zero counter, play register, timeout counter; -> ESPERA.
  - ESPERA (2): db_jogada=1 -> REGISTRA; else stay.
  - REGISTRA (4): load chaves into play register; -> COMPARA.
  - COMPARA (5): !db_igual -> FIM_ERRO; db_igual & contagem==DEPTH-1 -> FIM_ACERTO; else -> PROXIMO.
  - PROXIMO (6): contagem+1, clear timeout counter; -> ESPERA.
  - FIM_ACERTO (A): pronto=1, acertou=1; iniciar=1 -> PREPARA.
  - FIM_ERRO (E): pronto=1, errou=1; iniciar=1 -> PREPARA.
  - FIM_TIMEOUT (D, macro only): pronto=1, errou=1, db_timeout=1; iniciar=1 -> PREPARA.
- iniciar ignored in states 1,2,4,5,6.
- Unused codes -> INICIAL.
- Counter never wraps: the max value DEPTH-1 is terminal via COMPARA.
- Outputs pronto/acertou/errou/db_timeout are Moore decodes of the state.

## Timing
- Reset: state INICIAL, contagem 0, play register 0, prev 0, timeout counter 0. All flag outputs 0, db_estado 0.
- Reset asserted in any state returns to INICIAL on the next edge, dropping the round.
- Play latency: edge seen in ESPERA at cycle t -> REGISTRA at t+1 -> register valid and COMPARA at t+2 -> end state or PROXIMO at t+3 -> ESPERA at t+4.
- Switches held high yield exactly one play. A new play requires all switches to return to 0 first.
- Edge arriving outside ESPERA is lost; no buffering.
- PREPARA takes one cycle after iniciar; ESPERA is entered 2 cycles after iniciar is sampled in INICIAL.

## Configuration
- TIMEOUT_EN defined: a timeout counter increments each cycle in ESPERA.
  - Reaching TIMEOUT_CYCLES-1 without a play -> FIM_TIMEOUT.
  - A play edge in the same cycle as expiry wins (-> REGISTRA).
- TIMEOUT_EN undefined: no counter, ESPERA waits indefinitely, db_timeout tied 0, code D unreachable.

## Test plan
- Reset with DATA_W=4, DEPTH=4 -> db_estado=0, db_contagem=0, db_chaves=0, pronto=acertou=errou=0.
- Iniciar pulse, then plays 0001,0010,0100,1000 each followed by release to 0000 -> FIM_ACERTO: db_estado=A, acertou=1, pronto=1, db_contagem=3.
- Plays 0001 then 0100 -> FIM_ERRO: db_estado=E, errou=1, db_contagem=1, db_chaves=0100, db_igual=0.
- Hold 0001 high 20 cycles after the first play -> exactly one db_jogada pulse; state returns to ESPERA with db_contagem=1 and stays.
- Reset asserted in ESPERA with db_contagem=2 -> next cycle db_estado=0, db_contagem=0; afterwards iniciar from FIM_ERRO restarts at db_contagem=0.
- TIMEOUT_EN, TIMEOUT_CYCLES=8: iniciar, no play -> FIM_TIMEOUT (db_estado=D, db_timeout=1, errou=1) after 8 cycles in ESPERA; play edge on the expiry cycle -> REGISTRA instead.
